// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Control FSM for a multicycle RISC-V style datapath with a
//               shared, variable-latency memory and a retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [6:0]       Op_i,
    input  logic             Zero_i,
    input  logic             mem_ack_i,
    output logic             PCWrite_o,
    output logic             IRWrite_o,
    output logic             MemReq_o,
    output logic             MemWrite_o,
    output logic             IorD_o,
    output logic             ALUSrcA_o,
    output logic             RegWrite_o,
    output logic             MemtoReg_o,
    output logic             PCSrc_o,
    output logic             illegal_o,
    output logic [1:0]       ALUOp_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_R    = 3'd1,
        C_I    = 3'd2,
        C_LW   = 3'd3,
        C_SW   = 3'd4,
        C_BEQ  = 3'd5
    } class_t;

    localparam logic [6:0] C_OP_R   = 7'b0110011;
    localparam logic [6:0] C_OP_I   = 7'b0010011;
    localparam logic [6:0] C_OP_LW  = 7'b0000011;
    localparam logic [6:0] C_OP_SW  = 7'b0100011;
    localparam logic [6:0] C_OP_BEQ = 7'b1100011;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    class_t           r_class;
    class_t           w_dec_class;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;
    logic             w_retire;

    always_comb begin
        w_dec_class = C_NONE;
        case (Op_i)
            C_OP_R:   w_dec_class = C_R;
            C_OP_I:   w_dec_class = C_I;
            C_OP_LW:  w_dec_class = C_LW;
            C_OP_SW:  w_dec_class = C_SW;
            C_OP_BEQ: w_dec_class = C_BEQ;
            default:  w_dec_class = C_NONE;
        endcase
    end

    // Class is captured only while in DECODE, so Op_i may change freely afterwards.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_class   <= C_NONE;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_class <= w_dec_class;
                if (w_dec_class == C_NONE) begin
                    r_illegal <= 1'b1;
                end
            end
            if (w_retire) begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        PCWrite_o  = 1'b0;
        IRWrite_o  = 1'b0;
        MemReq_o   = 1'b0;
        MemWrite_o = 1'b0;
        IorD_o     = 1'b0;
        ALUSrcA_o  = 1'b0;
        RegWrite_o = 1'b0;
        MemtoReg_o = 1'b0;
        PCSrc_o    = 1'b0;
        ALUOp_o    = 2'b00;
        ALUSrcB_o  = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                MemReq_o  = 1'b1;
                ALUSrcB_o = 2'b01;
                if (mem_ack_i) begin
                    IRWrite_o = 1'b1;
                    PCWrite_o = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB_o = 2'b10;
                w_next    = (w_dec_class == C_NONE) ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
                ALUSrcA_o = 1'b1;
                case (r_class)
                    C_R: begin
                        ALUOp_o = 2'b10;
                        w_next  = S_WB;
                    end
                    C_I: begin
                        ALUSrcB_o = 2'b10;
                        ALUOp_o   = 2'b11;
                        w_next    = S_WB;
                    end
                    C_LW, C_SW: begin
                        ALUSrcB_o = 2'b10;
                        w_next    = S_MEM;
                    end
                    C_BEQ: begin
                        ALUOp_o   = 2'b01;
                        PCSrc_o   = 1'b1;
                        PCWrite_o = Zero_i;
                        w_retire  = 1'b1;
                        w_next    = S_FETCH;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                MemReq_o   = 1'b1;
                IorD_o     = 1'b1;
                MemWrite_o = (r_class == C_SW);
                if (mem_ack_i) begin
                    if (r_class == C_SW) begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next   = S_WB;
                    end
                end
            end
            S_WB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = (r_class == C_LW);
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign state_o     = r_state;
    assign illegal_o   = r_illegal;
    assign instr_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Instruction-level reference bench for multicycle_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [6:0]    Op_i = 7'd0;
    logic          Zero_i = 1'b0;
    logic          mem_ack_i = 1'b0;
    logic          PCWrite_o, IRWrite_o, MemReq_o, MemWrite_o, IorD_o;
    logic          ALUSrcA_o, RegWrite_o, MemtoReg_o, PCSrc_o, illegal_o;
    logic [1:0]    ALUOp_o, ALUSrcB_o;
    logic [2:0]    state_o;
    logic [CW-1:0] instr_cnt_o;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .Op_i(Op_i),
        .Zero_i(Zero_i), .mem_ack_i(mem_ack_i),
        .PCWrite_o(PCWrite_o), .IRWrite_o(IRWrite_o), .MemReq_o(MemReq_o),
        .MemWrite_o(MemWrite_o), .IorD_o(IorD_o), .ALUSrcA_o(ALUSrcA_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .PCSrc_o(PCSrc_o),
        .illegal_o(illegal_o), .ALUOp_o(ALUOp_o), .ALUSrcB_o(ALUSrcB_o),
        .state_o(state_o), .instr_cnt_o(instr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    logic [20:0] act;
    assign act = {state_o, PCWrite_o, IRWrite_o, MemReq_o, MemWrite_o, IorD_o,
                  ALUSrcA_o, RegWrite_o, MemtoReg_o, PCSrc_o, illegal_o,
                  ALUOp_o, ALUSrcB_o, instr_cnt_o};

    int n_tests = 0;
    int n_fail  = 0;
    int m_cnt   = 0;
    logic m_ill = 1'b0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // 0 illegal, 1 R, 2 I, 3 LW, 4 SW, 5 BEQ
    function automatic int classify(input logic [6:0] op);
        case (op)
            OP_R:    return 1;
            OP_I:    return 2;
            OP_LW:   return 3;
            OP_SW:   return 4;
            OP_BEQ:  return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom);
    endfunction

    function automatic logic [20:0] mk(input logic [2:0] st, input logic pcw, input logic irw,
                                       input logic mreq, input logic mwr, input logic iord,
                                       input logic srca, input logic rw, input logic m2r,
                                       input logic pcs, input logic [1:0] aluop,
                                       input logic [1:0] srcb);
        return {st, pcw, irw, mreq, mwr, iord, srca, rw, m2r, pcs, m_ill, aluop, srcb,
                CW'(m_cnt)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic st, input logic [6:0] op, input logic z, input logic ack,
                       input logic [20:0] exp, input string name);
        @(negedge clk_i);
        start_i   = st;
        Op_i      = op;
        Zero_i    = z;
        mem_ack_i = ack;
        #1;
        chk(name, 32'(act), 32'(exp));
    endtask

    task automatic retire();
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    task automatic start_seq(input int n_idle);
        for (int i = 0; i < n_idle; i++)
            cyc(1'b0, ro(), rb(), rb(), mk(3'd0, 0,0,0,0,0,0,0,0,0, 2'b00, 2'b00), "idle");
        cyc(1'b1, ro(), rb(), rb(), mk(3'd0, 0,0,0,0,0,0,0,0,0, 2'b00, 2'b00), "idle_start");
    endtask

    // One instruction, fetch acked after fw wait cycles and memory after mw.
    // rst_at >= 0 asserts reset after that MEM wait cycle and abandons the instruction.
    task automatic do_instr(input logic [6:0] op, input logic z, input int fw, input int mw,
                            input int rst_at);
        int cls;
        logic sw;
        for (int i = 0; i < fw; i++)
            cyc(rb(), ro(), rb(), 1'b0, mk(3'd1, 0,0,1,0,0,0,0,0,0, 2'b00, 2'b01), "fetch_wait");
        cyc(rb(), ro(), rb(), 1'b1, mk(3'd1, 1,1,1,0,0,0,0,0,0, 2'b00, 2'b01), "fetch_ack");
        cyc(rb(), op, rb(), rb(), mk(3'd2, 0,0,0,0,0,0,0,0,0, 2'b00, 2'b10), "decode");
        cls = classify(op);
        if (cls == 0) begin
            m_ill = 1'b1;
            return;
        end
        case (cls)
            1: cyc(rb(), ro(), rb(), rb(), mk(3'd3, 0,0,0,0,0,1,0,0,0, 2'b10, 2'b00), "exec_r");
            2: cyc(rb(), ro(), rb(), rb(), mk(3'd3, 0,0,0,0,0,1,0,0,0, 2'b11, 2'b10), "exec_i");
            3, 4: cyc(rb(), ro(), rb(), rb(), mk(3'd3, 0,0,0,0,0,1,0,0,0, 2'b00, 2'b10), "exec_mem");
            default: cyc(rb(), ro(), z, rb(), mk(3'd3, z,0,0,0,0,1,0,0,1, 2'b01, 2'b00), "exec_beq");
        endcase
        if (cls == 5) begin
            retire();
            return;
        end
        if (cls == 3 || cls == 4) begin
            sw = (cls == 4);
            for (int i = 0; i < mw; i++) begin
                cyc(rb(), ro(), rb(), 1'b0, mk(3'd4, 0,0,1,sw,1,0,0,0,0, 2'b00, 2'b00), "mem_wait");
                if (i == rst_at) begin
                    #1;
                    start_i = 1'b0;
                    rst_i   = 1'b0;
                    #1;
                    chk("rst_async", 32'(act), 32'd0);
                    @(negedge clk_i);
                    chk("rst_hold", 32'(act), 32'd0);
                    rst_i = 1'b1;
                    m_cnt = 0;
                    m_ill = 1'b0;
                    return;
                end
            end
            cyc(rb(), ro(), rb(), 1'b1, mk(3'd4, 0,0,1,sw,1,0,0,0,0, 2'b00, 2'b00), "mem_ack");
            if (sw) begin
                retire();
                return;
            end
        end
        cyc(rb(), ro(), rb(), rb(), mk(3'd5, 0,0,0,0,0,0,1,(cls == 3),0, 2'b00, 2'b00), "wb");
        retire();
    endtask

    task automatic after_edge();
        @(posedge clk_i);
        #1;
    endtask

    logic [6:0] ops [5];

    initial begin
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LW; ops[3] = OP_SW; ops[4] = OP_BEQ;

        #1;
        chk("reset_state", 32'(act), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        start_seq(3);
        do_instr(OP_R, 1'b0, 0, 0, -1);
        after_edge();
        chk("r_first_cnt", 32'(instr_cnt_o), 32'd1);
        chk("r_back_fetch", 32'(state_o), 32'd1);

        do_instr(OP_LW, 1'b0, 3, 2, -1);
        do_instr(OP_BEQ, 1'b1, 1, 0, -1);
        do_instr(OP_BEQ, 1'b0, 0, 0, -1);
        do_instr(OP_SW, 1'b0, 2, 1, -1);
        do_instr(7'b1111111, 1'b0, 0, 0, -1);
        do_instr(OP_R, 1'b0, 1, 0, -1);
        after_edge();
        chk("directed_cnt", 32'(instr_cnt_o), 32'd6);
        chk("illegal_sticky", 32'(illegal_o), 32'd1);

        for (int n = 0; n < 40; n++) begin
            int k;
            logic [6:0] op;
            k  = $urandom_range(0, 5);
            op = (k == 5) ? ro() : ops[k];
            do_instr(op, rb(), $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end

        do_instr(OP_LW, 1'b0, 0, 3, 1);
        start_seq(2);
        for (int n = 0; n < 16; n++)
            do_instr(n[0] ? OP_I : OP_R, 1'b0, 0, 0, -1);
        after_edge();
        chk("cnt_wrap", 32'(instr_cnt_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
